tiny8_memory: RTL and testbench
===============================

# tiny8_memory

Single-port byte memory that answers the tiny8 datapath's memory requests. It samples `mem_addr`, `mem_wdata` and the control unit's `mem_read`/`mem_write` strobes, and after a fixed, parameterised latency returns `mem_rdata` with a one-cycle `mem_resp` pulse. It also has a side-band load port used by benches and boot logic to fill the array while the CPU is idle.

## Interface
- `LATENCY`, default 2: cycles from request acceptance to the `mem_resp` cycle. Legal range 1..15.
- `DEPTH`, default 256: number of bytes. Addresses at or above `DEPTH` wrap modulo `DEPTH`.
- `clk`  in  1  clock. All state changes on the rising edge.
- `rst_n`  in  1  reset. Asynchronous, active-low.
- `mem_read`  in  1  read request. Level, held by the CPU until `mem_resp`.
- `mem_write`  in  1  write request. Level, held by the CPU until `mem_resp`.
- `mem_addr`  in  8  byte address (tiny8_word).
- `mem_wdata`  in  8  write data (tiny8_word).
- `mem_rdata`  out  8  read data. Valid in the `mem_resp` cycle of a read.
- `mem_resp`  out  1  one-cycle completion pulse.
- `ld_en`  in  1  load-port write strobe.
- `ld_addr`  in  8  load-port address.
- `ld_data`  in  8  load-port data.
- `ld_ack`  out  1  load accepted. Asserted in the cycle after the accepting edge.
- `err`  out  1  sticky flag: `mem_read` and `mem_write` were both high at acceptance.

## Operation
- States:
  - IDLE: accepting requests.
  - WAIT: counting down the remaining latency.
  - RESP: responding.
- Array contents are not reset. Control state and all outputs are reset.
- IDLE, `mem_read | mem_write` high at an edge:
  - Capture address, write data and operation.
  - If `LATENCY==1`, go to RESP. Otherwise go to WAIT and load the counter with `LATENCY-1`.
- WAIT: decrement the counter each edge. When the counter reaches 0, go to RESP.
- Captured values are used for the whole transaction. Changes on `mem_addr`/`mem_wdata` after acceptance are ignored.
- RESP:
  - `mem_resp=1`.
  - Read: `mem_rdata` = array[captured addr].
  - Write: the array is written on the edge that ends RESP.
  - Next state is always IDLE. The CPU deasserts its strobe on seeing `mem_resp`. A strobe still high in the IDLE cycle that follows counts as a new request.
- Both strobes high at acceptance: perform a read only, suppress the write, set `err`. `err` clears only on reset.
- Load port:
  - A load is accepted only in IDLE with both strobes low. The array is written on that edge and `ld_ack` pulses for one cycle.
  - `ld_en` in any other state, or simultaneous with a CPU request in IDLE, is ignored (no `ld_ack`). CPU requests have priority.
- `mem_rdata` is registered and holds the last read value between reads. Writes do not change it.

## Timing
- Reset values: state IDLE, `mem_resp=0`, `mem_rdata=8'h00`, `ld_ack=0`, `err=0`, counter 0.
- Request high in cycle 0 (accepted at the end of cycle 0): `mem_resp` is high exactly in cycle `LATENCY`.
- Back-to-back throughput: one transaction per `LATENCY+1` cycles. The extra cycle is the mandatory IDLE after RESP.
- Read-after-write to the same address: the read issued in the IDLE after the write's RESP returns the new data.
- Load then read of the same address: the read issued in the cycle after `ld_ack` returns `ld_data`.
- `rst_n` low mid-transaction:
  - Immediate return to IDLE; outputs take their reset values.
  - A pending write is dropped and the array is not modified.
  - No `mem_resp` is issued for the aborted request.
- `mem_resp` is never high for two consecutive cycles.

## Test plan
- Reset, then load addr 8'h10=8'hA5 (`ld_ack` pulses once); `mem_read` addr 8'h10 with `LATENCY=2` -> `mem_resp` high two cycles after the request, `mem_rdata=8'hA5`, held afterwards.
- Write 8'h3C to 8'hFF, then read 8'hFF on the next IDLE -> read returns 8'h3C. Sweep `LATENCY` = 1, 2, 7 and check the `mem_resp` cycle equals `LATENCY` each time.
- Change `mem_addr` to 8'h00 during WAIT of a read of 8'h10 -> data is still array[8'h10]. With `DEPTH=128`, addr 8'h90 aliases 8'h10.
- Assert both strobes with addr 8'h20 -> `err`=1 and stays 1; read data returned; array[8'h20] unchanged.
- `ld_en` during WAIT, and `ld_en` together with `mem_read` in IDLE -> no `ld_ack`, array unchanged.
- Deassert `rst_n` in WAIT of a write of 8'h77 to 8'h05 (array[8'h05] preloaded 8'h11) -> no `mem_resp`; after reset, a read of 8'h05 returns 8'h11 and `mem_rdata` was 8'h00 during reset.

Source files
------------

// File: rtl/tiny8_memory.sv
// Single-port byte memory for the tiny8 datapath: fixed-latency CPU port with a
// one-cycle response pulse, plus a side-band load port usable only while idle.
module tiny8_memory #(
   parameter int unsigned LATENCY = 2,
   parameter int unsigned DEPTH   = 256
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       mem_read,
   input  logic       mem_write,
   input  logic [7:0] mem_addr,
   input  logic [7:0] mem_wdata,
   output logic [7:0] mem_rdata,
   output logic       mem_resp,
   input  logic       ld_en,
   input  logic [7:0] ld_addr,
   input  logic [7:0] ld_data,
   output logic       ld_ack,
   output logic       err
);

   localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t          state, state_nx;
   logic [3:0]      cnt;
   logic [AW-1:0]   cap_idx;
   logic [7:0]      cap_wdata;
   logic            cap_rd;
   logic            cap_wr;
   logic [7:0]      mem [DEPTH];

   logic            req;
   logic            accept;
   logic            ld_accept;
   logic            mem_we;
   logic            rd_load;
   logic [AW-1:0]   req_idx;
   logic [AW-1:0]   ld_idx;
   logic [AW-1:0]   rd_idx;

   assign req       = mem_read | mem_write;
   assign accept    = (state == IDLE) && req;
   assign ld_accept = (state == IDLE) && !req && ld_en;
   assign mem_we    = (state == RESP) && cap_wr;
   assign req_idx   = AW'(32'(mem_addr) % DEPTH);
   assign ld_idx    = AW'(32'(ld_addr) % DEPTH);
   assign mem_resp  = (state == RESP);

   // With LATENCY==1 the read data is fetched on the accepting edge, so the
   // live address is used; otherwise the captured one.
   assign rd_idx  = (state == IDLE) ? req_idx : cap_idx;
   assign rd_load = (state_nx == RESP) && ((state == IDLE) ? mem_read : cap_rd);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (req) state_nx = (LATENCY == 1) ? RESP : WAIT;
         WAIT:    if (cnt <= 4'd1) state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         cap_idx   <= '0;
         cap_wdata <= '0;
         cap_rd    <= 1'b0;
         cap_wr    <= 1'b0;
         mem_rdata <= '0;
         ld_ack    <= 1'b0;
         err       <= 1'b0;
      end else begin
         ld_ack <= ld_accept;
         if (accept) begin
            cnt       <= CNT_INIT;
            cap_idx   <= req_idx;
            cap_wdata <= mem_wdata;
            cap_rd    <= mem_read;
            cap_wr    <= mem_write & ~mem_read;
            if (mem_read && mem_write) err <= 1'b1;
         end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
         end
         if (rd_load) mem_rdata <= mem[rd_idx];
      end
   end

   // Array is not reset; writes are held off while reset is asserted so an
   // aborted transaction or a stray load cannot modify it.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (mem_we)         mem[cap_idx] <= cap_wdata;
         else if (ld_accept) mem[ld_idx]  <= ld_data;
      end
   end

endmodule

// File: tb/tb_tiny8_memory.sv
// Bench for tiny8_memory: three instances (LATENCY 2/256, 1/256, 7/128) with a
// queue-based scoreboard checked by a monitor whenever mem_resp is seen.
module tb_tiny8_memory;

   localparam int unsigned LAT [3] = '{2, 1, 7};

   typedef struct {
      int unsigned cyc;
      logic [7:0]  data;
      bit          rd;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rd     [3];
   logic       wr     [3];
   logic [7:0] addr   [3];
   logic [7:0] wd     [3];
   logic [7:0] rdata  [3];
   logic       resp   [3];
   logic       ldn    [3];
   logic [7:0] ldaddr [3];
   logic [7:0] lddata [3];
   logic       ack    [3];
   logic       err    [3];

   int unsigned cyc = 0;
   int unsigned total = 0;
   int unsigned bad = 0;
   exp_t        sb [3][$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   tiny8_memory #(.LATENCY(2), .DEPTH(256)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .mem_read(rd[0]), .mem_write(wr[0]),
      .mem_addr(addr[0]), .mem_wdata(wd[0]), .mem_rdata(rdata[0]), .mem_resp(resp[0]),
      .ld_en(ldn[0]), .ld_addr(ldaddr[0]), .ld_data(lddata[0]), .ld_ack(ack[0]), .err(err[0]));

   tiny8_memory #(.LATENCY(1), .DEPTH(256)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .mem_read(rd[1]), .mem_write(wr[1]),
      .mem_addr(addr[1]), .mem_wdata(wd[1]), .mem_rdata(rdata[1]), .mem_resp(resp[1]),
      .ld_en(ldn[1]), .ld_addr(ldaddr[1]), .ld_data(lddata[1]), .ld_ack(ack[1]), .err(err[1]));

   tiny8_memory #(.LATENCY(7), .DEPTH(128)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .mem_read(rd[2]), .mem_write(wr[2]),
      .mem_addr(addr[2]), .mem_wdata(wd[2]), .mem_rdata(rdata[2]), .mem_resp(resp[2]),
      .ld_en(ldn[2]), .ld_addr(ldaddr[2]), .ld_data(lddata[2]), .ld_ack(ack[2]), .err(err[2]));

   task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic check1(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic monitor_loop();
      exp_t e;
      bit   prev [3];
      prev = '{0, 0, 0};
      forever begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            if (resp[i] === 1'b1) begin
               check1($sformatf("resp_single_cycle[%0d]", i), prev[i], 1'b0);
               if (sb[i].size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_resp[%0d]: got resp at cycle %0d expected none", i, cyc);
               end else begin
                  e = sb[i].pop_front();
                  total++;
                  if (cyc != e.cyc) begin
                     bad++;
                     $display("FAIL resp_cycle[%0d]: got %0d expected %0d", i, cyc, e.cyc);
                  end
                  if (e.rd) check8($sformatf("rdata[%0d]", i), rdata[i], e.data);
               end
            end
            prev[i] = (resp[i] === 1'b1);
         end
      end
   endtask

   // Issue one request in the current cycle; expected response is queued for the monitor.
   // a2 replaces mem_addr after acceptance; with_ld holds ld_en high throughout.
   task automatic do_req(input int i, input logic r, input logic w, input logic [7:0] a,
                         input logic [7:0] a2, input logic [7:0] d, input logic [7:0] exp_d,
                         input logic with_ld);
      exp_t e;
      rd[i] = r;  wr[i] = w;  addr[i] = a;  wd[i] = d;
      if (with_ld) begin
         ldn[i] = 1'b1;  ldaddr[i] = a;  lddata[i] = 8'hEE;
      end
      e.cyc = cyc + LAT[i];
      e.data = exp_d;
      e.rd = r;
      sb[i].push_back(e);
      for (int k = 0; k < int'(LAT[i]); k++) begin
         @(posedge clk); #1;
         addr[i] = a2;
         wd[i] = ~d;
         if (with_ld) check1("ld_ignored_busy", ack[i], 1'b0);
      end
      @(posedge clk); #1;
      rd[i] = 1'b0;  wr[i] = 1'b0;  ldn[i] = 1'b0;
      if (with_ld) check1("ld_ignored_after", ack[i], 1'b0);
   endtask

   task automatic do_load(input int i, input logic [7:0] a, input logic [7:0] d);
      ldn[i] = 1'b1;  ldaddr[i] = a;  lddata[i] = d;
      @(posedge clk); #1;
      ldn[i] = 1'b0;
      check1("ld_ack_pulse", ack[i], 1'b1);
      @(posedge clk); #1;
      check1("ld_ack_single", ack[i], 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rd[i] = 1'b0;  wr[i] = 1'b0;  addr[i] = '0;  wd[i] = '0;
         ldn[i] = 1'b0; ldaddr[i] = '0; lddata[i] = '0;
      end
      fork
         monitor_loop();
      join_none

      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         check8("reset_rdata", rdata[i], 8'h00);
         check1("reset_resp", resp[i], 1'b0);
         check1("reset_ld_ack", ack[i], 1'b0);
         check1("reset_err", err[i], 1'b0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;

      // LATENCY=2 instance
      do_load(0, 8'h10, 8'hA5);
      do_load(0, 8'h00, 8'h5A);
      do_req(0, 1'b1, 1'b0, 8'h10, 8'h10, 8'h00, 8'hA5, 1'b0);
      @(posedge clk); #1;
      check8("rdata_held", rdata[0], 8'hA5);
      do_req(0, 1'b0, 1'b1, 8'hFF, 8'hFF, 8'h3C, 8'h00, 1'b0);
      check8("rdata_after_write", rdata[0], 8'hA5);
      do_req(0, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'h00, 8'h3C, 1'b0);
      do_req(0, 1'b1, 1'b0, 8'h10, 8'h00, 8'h00, 8'hA5, 1'b0);
      do_load(0, 8'h20, 8'hC3);
      do_req(0, 1'b1, 1'b1, 8'h20, 8'h20, 8'h99, 8'hC3, 1'b0);
      check1("err_set", err[0], 1'b1);
      do_req(0, 1'b1, 1'b0, 8'h20, 8'h20, 8'h00, 8'hC3, 1'b0);
      check1("err_sticky", err[0], 1'b1);
      do_req(0, 1'b1, 1'b0, 8'h10, 8'h10, 8'h00, 8'hA5, 1'b1);
      do_req(0, 1'b1, 1'b0, 8'h10, 8'h10, 8'h00, 8'hA5, 1'b0);

      // reset during WAIT of a write
      do_load(0, 8'h05, 8'h11);
      wr[0] = 1'b1;  addr[0] = 8'h05;  wd[0] = 8'h77;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check8("abort_rdata", rdata[0], 8'h00);
      check1("abort_resp", resp[0], 1'b0);
      check1("abort_err", err[0], 1'b0);
      wr[0] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check1("abort_resp_hold", resp[0], 1'b0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_req(0, 1'b1, 1'b0, 8'h05, 8'h05, 8'h00, 8'h11, 1'b0);

      // LATENCY=1 instance
      do_load(1, 8'h10, 8'hA5);
      do_req(1, 1'b1, 1'b0, 8'h10, 8'h10, 8'h00, 8'hA5, 1'b0);
      do_req(1, 1'b0, 1'b1, 8'hFF, 8'hFF, 8'h3C, 8'h00, 1'b0);
      do_req(1, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'h00, 8'h3C, 1'b0);

      // LATENCY=7, DEPTH=128 instance: 8'h90 aliases 8'h10
      do_req(2, 1'b0, 1'b1, 8'h10, 8'h10, 8'h5E, 8'h00, 1'b0);
      do_req(2, 1'b1, 1'b0, 8'h90, 8'h90, 8'h00, 8'h5E, 1'b0);
      do_req(2, 1'b0, 1'b1, 8'hFF, 8'hFF, 8'h3C, 8'h00, 1'b0);
      do_req(2, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'h00, 8'h3C, 1'b0);

      for (int k = 0; k < 50 && (sb[0].size() + sb[1].size() + sb[2].size()) != 0; k++)
         @(posedge clk);
      repeat (3) @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         if (sb[i].size() != 0) begin
            total++;
            bad++;
            $display("FAIL missing_resp[%0d]: got none, expected %0d more responses", i, sb[i].size());
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
